// File: rtl/pipe_if_stage_pkg.sv
// Shared types and encodings for the instruction-fetch stage.
// Used by pipe_if_stage, pipe_if_nextpc and the imem interface.
package pipe_if_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        REQ,
        HOLD
    } if_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] dpc4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory request/ready handshake.
// master = fetch stage, slave = memory.
interface pipe_if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/pipe_if_nextpc.sv
// Next-PC select for the fetch stage: redirect target mux and
// the pending-redirect register that waits for the delay slot.
module pipe_if_nextpc
    import pipe_if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        id_valid,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    input  logic [31:0] pc,
    input  logic        xfer,
    input  logic        fetching,
    output logic [31:0] pc4,
    output logic [31:0] target,
    output logic        redir_ev,
    output logic [31:0] nextpc
);

    logic        redir_pend;
    logic [31:0] redir_pc;

    assign pc4      = pc + 32'd4;
    assign redir_ev = id_valid & ~stall & (pcsource != PCSRC_SEQ);

    // Target select from ID, forced to a word boundary.
    always_comb begin
        target = pc4;
        unique case (pcsource)
            PCSRC_SEQ: target = pc4;
            PCSRC_BR:  target = word_align(bpc);
            PCSRC_JR:  target = word_align(ra);
            PCSRC_J:   target = word_align(jpc);
        endcase
    end

    // A pending redirect wins; then a live redirect; else sequential.
    always_comb begin
        nextpc = pc4;
        if (redir_pend)
            nextpc = redir_pc;
        else if (redir_ev)
            nextpc = target;
    end

    // Park the target until the in-flight delay slot completes.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            redir_pend <= 1'b0;
            redir_pc   <= 32'h0;
        end else if (xfer) begin
            redir_pend <= 1'b0;
        end else if (redir_ev & fetching & ~redir_pend) begin
            redir_pend <= 1'b1;
            redir_pc   <= target;
        end
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage with IF/ID register and 1-entry hold buffer.
// Optional PIPEIF_PERFCNT_EN adds fetch_cnt / stall_cnt outputs.
module pipe_if_stage
    import pipe_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               stall,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        ra,
    input  logic [31:0]        jpc,
    pipe_if_stage_if.master    imem,
    output logic [31:0]        inst,
    output logic [31:0]        dpc4,
    output logic               id_valid,
    output logic               if_busy
`ifdef PIPEIF_PERFCNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    if_state_t   state, state_nx;
    if_id_t      ifid, ifid_nx;
    logic        run;
    logic [31:0] pc, pc_nx;
    logic [31:0] hold_inst, hold_dpc4;
    logic        hold_ld;
    logic        xfer;
    logic [31:0] pc4, target, nextpc;
    logic        redir_ev;

    assign imem.imem_req  = run & (state == REQ);
    assign imem.imem_addr = pc;
    assign xfer           = imem.imem_req & imem.imem_ready;
    assign if_busy        = (state == REQ) & imem.imem_req;
    assign inst           = ifid.inst;
    assign dpc4           = ifid.dpc4;
    assign id_valid       = ifid.valid;

    pipe_if_nextpc u_nextpc (
        .clk      (clk),
        .clrn     (clrn),
        .id_valid (ifid.valid),
        .stall    (stall),
        .pcsource (pcsource),
        .bpc      (bpc),
        .ra       (ra),
        .jpc      (jpc),
        .pc       (pc),
        .xfer     (xfer),
        .fetching (imem.imem_req),
        .pc4      (pc4),
        .target   (target),
        .redir_ev (redir_ev),
        .nextpc   (nextpc)
    );

    // PC advances on completion; leaving HOLD on a redirect steers it
    // directly since the held delay slot has already been fetched.
    always_comb begin
        pc_nx = pc;
        if (xfer)
            pc_nx = nextpc;
        else if ((state == HOLD) & redir_ev)
            pc_nx = target;
    end

    // Fetch FSM and IF/ID update; stall freezes IF/ID everywhere.
    always_comb begin
        state_nx = state;
        ifid_nx  = ifid;
        hold_ld  = 1'b0;
        unique case (state)
            REQ: begin
                if (xfer) begin
                    if (stall) begin
                        hold_ld  = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        ifid_nx = '{inst: imem.imem_rdata,
                                    dpc4: pc4, valid: 1'b1};
                    end
                end else if (!stall) begin
                    ifid_nx = '{inst: NOP_INST,
                                dpc4: ifid.dpc4, valid: 1'b0};
                end
            end
            HOLD: begin
                if (!stall) begin
                    ifid_nx  = '{inst: hold_inst,
                                 dpc4: hold_dpc4, valid: 1'b1};
                    state_nx = REQ;
                end
            end
        endcase
    end

    // State, PC, IF/ID and hold-buffer registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= REQ;
            run       <= 1'b0;
            pc        <= RESET_PC;
            ifid      <= '{inst: NOP_INST, dpc4: 32'h0, valid: 1'b0};
            hold_inst <= 32'h0;
            hold_dpc4 <= 32'h0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
            pc    <= pc_nx;
            ifid  <= ifid_nx;
            if (hold_ld) begin
                hold_inst <= imem.imem_rdata;
                hold_dpc4 <= pc4;
            end
        end
    end

`ifdef PIPEIF_PERFCNT_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (xfer)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed scenarios plus a
// randomized run against a fetch-order / delay-slot reference model.
module tb_pipe_if_stage;
    import pipe_if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0, ra = 32'h0, jpc = 32'h0;
    logic [31:0] inst, dpc4;
    logic        id_valid, if_busy;
`ifdef PIPEIF_PERFCNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_if_stage_if imem ();

    always #5 clk = ~clk;

    pipe_if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .stall    (stall),
        .pcsource (pcsource),
        .bpc      (bpc),
        .ra       (ra),
        .jpc      (jpc),
        .imem     (imem),
        .inst     (inst),
        .dpc4     (dpc4),
        .id_valid (id_valid),
        .if_busy  (if_busy)
`ifdef PIPEIF_PERFCNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic tick(input logic rdy, input logic stl,
                        input logic [1:0] pcs, input logic [31:0] tgt);
        imem.imem_ready = rdy;
        imem.imem_rdata = mem(imem.imem_addr);
        stall    = stl;
        pcsource = pcs;
        bpc = tgt;
        ra  = tgt;
        jpc = tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        clrn = 1'b0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        stall = 1'b0;
        pcsource = 2'b00;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        tick(1'b0, 1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({imem.imem_req, if_busy, id_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: req/busy/valid=%b want 000",
                     {imem.imem_req, if_busy, id_valid});
        end
        checks++;
        if (inst !== NOP || dpc4 !== 32'h0 || imem.imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_data: inst=%h dpc4=%h addr=%h want %h 0 %h",
                     inst, dpc4, imem.imem_addr, NOP, RST_PC);
        end
        clrn = 1'b1;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req: got %b want 0", imem.imem_req);
        end
        @(negedge clk);
        tick(1'b0, 1'b0, 2'b00, 32'h0);
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1 %h",
                     imem.imem_req, imem.imem_addr, RST_PC);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a = 32'(i * 4);
            checks++;
            if (imem.imem_addr !== a) begin
                errors++;
                $display("FAIL zw_addr: got %h want %h", imem.imem_addr, a);
            end
            tick(1'b1, 1'b0, 2'b00, 32'h0);
            checks++;
            if (inst !== mem(a) || dpc4 !== a + 4 || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL zw_ifid: inst=%h dpc4=%h v=%b want %h %h 1",
                         inst, dpc4, id_valid, mem(a), a + 4);
            end
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 4);
            for (int w = 0; w < 3; w++) begin
                tick(1'b0, 1'b0, 2'b00, 32'h0);
                checks++;
                if (imem.imem_addr !== a || id_valid !== 1'b0 ||
                    inst !== NOP || dpc4 !== a) begin
                    errors++;
                    $display("FAIL ws_wait: addr=%h v=%b inst=%h dpc4=%h want %h 0 %h %h",
                             imem.imem_addr, id_valid, inst, dpc4, a, NOP, a);
                end
            end
            tick(1'b1, 1'b0, 2'b00, 32'h0);
            checks++;
            if (inst !== mem(a) || dpc4 !== a + 4 || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL ws_ifid: inst=%h dpc4=%h v=%b want %h %h 1",
                         inst, dpc4, id_valid, mem(a), a + 4);
            end
        end
    endtask

    task automatic test_stall_hold;
        do_reset();
        repeat (4) tick(1'b1, 1'b0, 2'b00, 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick(c == 0, 1'b1, 2'b00, 32'h0);
            checks++;
            if (inst !== mem(32'hC) || dpc4 !== 32'h10 || id_valid !== 1'b1 ||
                imem.imem_req !== 1'b0 || if_busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen: inst=%h dpc4=%h v=%b req=%b busy=%b want %h 10 1 0 0",
                         inst, dpc4, id_valid, imem.imem_req, if_busy, mem(32'hC));
            end
        end
        tick(1'b0, 1'b0, 2'b00, 32'h0);
        checks++;
        if (inst !== mem(32'h10) || dpc4 !== 32'h14 || id_valid !== 1'b1 ||
            imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL hold_release: inst=%h dpc4=%h v=%b req=%b addr=%h want %h 14 1 1 14",
                     inst, dpc4, id_valid, imem.imem_req, imem.imem_addr, mem(32'h10));
        end
    endtask

    task automatic test_branch_redirect;
        do_reset();
        repeat (9) tick(1'b1, 1'b0, 2'b00, 32'h0);
        tick(1'b0, 1'b0, PCSRC_BR, 32'h100);
        checks++;
        if (id_valid !== 1'b0 || imem.imem_addr !== 32'h24) begin
            errors++;
            $display("FAIL br_wait: v=%b addr=%h want 0 24", id_valid, imem.imem_addr);
        end
        tick(1'b0, 1'b0, PCSRC_BR, 32'h300);
        tick(1'b1, 1'b0, PCSRC_SEQ, 32'h0);
        checks++;
        if (inst !== mem(32'h24) || dpc4 !== 32'h28 || imem.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL br_target: inst=%h dpc4=%h addr=%h want %h 28 100",
                     inst, dpc4, imem.imem_addr, mem(32'h24));
        end
    endtask

    task automatic test_jr;
        do_reset();
        tick(1'b0, 1'b0, PCSRC_JR, 32'h200);
        tick(1'b1, 1'b0, PCSRC_JR, 32'h200);
        checks++;
        if (inst !== mem(32'h0) || imem.imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL jr_ignored: inst=%h addr=%h want %h 4", inst, imem.imem_addr, mem(0));
        end
        tick(1'b1, 1'b0, PCSRC_JR, 32'h203);
        checks++;
        if (inst !== mem(32'h4) || dpc4 !== 32'h8 || imem.imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL jr_direct: inst=%h dpc4=%h addr=%h want %h 8 200",
                     inst, dpc4, imem.imem_addr, mem(32'h4));
        end
        tick(1'b1, 1'b0, PCSRC_SEQ, 32'h0);
        checks++;
        if (inst !== mem(32'h200) || dpc4 !== 32'h204 || imem.imem_addr !== 32'h204) begin
            errors++;
            $display("FAIL jr_after: inst=%h dpc4=%h addr=%h want %h 204 204",
                     inst, dpc4, imem.imem_addr, mem(32'h200));
        end
    endtask

    task automatic test_reset_mid_fetch;
        do_reset();
        repeat (16) tick(1'b1, 1'b0, 2'b00, 32'h0);
        tick(1'b0, 1'b0, 2'b00, 32'h0);
        clrn = 1'b0;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0 || inst !== NOP || dpc4 !== 32'h0 ||
            id_valid !== 1'b0 || imem.imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL rst_mid: req=%b inst=%h dpc4=%h v=%b addr=%h",
                     imem.imem_req, inst, dpc4, id_valid, imem.imem_addr);
        end
        imem.imem_ready = 1'b1;
        @(negedge clk);
        clrn = 1'b1;
        tick(1'b1, 1'b0, 2'b00, 32'h0);
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== RST_PC || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale: req=%b addr=%h v=%b want 1 %h 0",
                     imem.imem_req, imem.imem_addr, id_valid, RST_PC);
        end
        tick(1'b1, 1'b0, 2'b00, 32'h0);
        checks++;
        if (inst !== mem(RST_PC) || dpc4 !== RST_PC + 4) begin
            errors++;
            $display("FAIL rst_refetch: inst=%h dpc4=%h want %h %h",
                     inst, dpc4, mem(RST_PC), RST_PC + 4);
        end
    endtask

    task automatic test_random;
        logic [31:0] ea   [0:4095];
        logic        ov_v [0:4095];
        logic [31:0] ov_a [0:4095];
        int          nf = 0;
        int          last_k = -1;
        int          wl = 0;
        logic        p_stall = 1'b0, p_valid = 1'b0, p_wait = 1'b0;
        logic [31:0] p_addr = 32'h0, p_inst = 32'h0, p_dpc4 = 32'h0;
        logic        stl, rdy;
        logic [1:0]  pcs;
        logic [31:0] tgt, e;
        for (int i = 0; i < 4096; i++) ov_v[i] = 1'b0;
        do_reset();
        repeat (3000) begin
            if (p_stall) begin
                checks++;
                if ({id_valid, inst, dpc4} !== {p_valid, p_inst, p_dpc4}) begin
                    errors++;
                    $display("FAIL rnd_freeze: v=%b inst=%h dpc4=%h want %b %h %h",
                             id_valid, inst, dpc4, p_valid, p_inst, p_dpc4);
                end
            end else if (id_valid) begin
                last_k++;
                checks++;
                if (last_k >= nf) begin
                    errors++;
                    $display("FAIL rnd_order: delivered #%0d but only %0d fetched", last_k, nf);
                end else if (inst !== mem(ea[last_k]) || dpc4 !== ea[last_k] + 4) begin
                    errors++;
                    $display("FAIL rnd_ifid: #%0d inst=%h dpc4=%h want %h %h",
                             last_k, inst, dpc4, mem(ea[last_k]), ea[last_k] + 4);
                end
            end
            if (p_wait && imem.imem_req) begin
                checks++;
                if (imem.imem_addr !== p_addr) begin
                    errors++;
                    $display("FAIL rnd_stable: addr=%h want %h", imem.imem_addr, p_addr);
                end
            end
            stl = ($urandom_range(0, 3) == 0);
            pcs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(0, 4095));
            if (id_valid && !stl && pcs != 2'b00 && last_k >= 0) begin
                ov_v[last_k + 2] = 1'b1;
                ov_a[last_k + 2] = tgt & ~32'h3;
            end
            rdy = 1'b0;
            if (imem.imem_req) begin
                if (!p_wait) wl = $urandom_range(0, 3);
                if (wl == 0) begin
                    e = ov_v[nf] ? ov_a[nf] : (nf == 0 ? RST_PC : ea[nf - 1] + 4);
                    checks++;
                    if (imem.imem_addr !== e) begin
                        errors++;
                        $display("FAIL rnd_addr: fetch #%0d addr=%h want %h",
                                 nf, imem.imem_addr, e);
                    end
                    ea[nf] = e;
                    nf++;
                    rdy = 1'b1;
                end else begin
                    wl--;
                end
            end else begin
                rdy = ($urandom_range(0, 1) == 1);
            end
            p_wait  = imem.imem_req && !rdy;
            p_addr  = imem.imem_addr;
            p_stall = stl;
            p_valid = id_valid;
            p_inst  = inst;
            p_dpc4  = dpc4;
            tick(rdy, stl, pcs, tgt);
        end
        checks++;
        if (nf - 1 - last_k < 0 || nf - 1 - last_k > 1) begin
            errors++;
            $display("FAIL rnd_drain: fetched %0d delivered %0d", nf, last_k + 1);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch_redirect();
        test_jr();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
